keyboard_pitch_mapper: RTL and testbench

//  Parametrised successor to the single-key free-play mapper. Maps 7 note switches plus a sharp

---
 rtl/keyboard_pitch_mapper.sv | 161 ++++++++++++++++
 tb/tb_keyboard_pitch_mapper.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/keyboard_pitch_mapper.sv
// Maps seven note switches plus a sharp modifier to a registered tone frequency,
// with saturating octave select, selectable multi-key priority and sustain.
module keyboard_pitch_mapper #(
    parameter int NUM_OCTAVES = 3,
    parameter int MID_OCTAVE  = 1,
    parameter int FREQ_W      = 12,
    parameter int PRIORITY    = 0,
    localparam int OCT_W      = (NUM_OCTAVES > 1) ? $clog2(NUM_OCTAVES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              oct_up,
    input  logic              oct_dn,
    input  logic              hold,
    input  logic [7:0]        sw,
    output logic [FREQ_W-1:0] frequency,
    output logic [3:0]        note,
    output logic              sharp,
    output logic [OCT_W-1:0]  octave,
    output logic              note_chg
);

    localparam logic [OCT_W-1:0] OCT_MAX   = OCT_W'(NUM_OCTAVES - 1);
    localparam logic [OCT_W-1:0] OCT_RESET = OCT_W'(MID_OCTAVE);

    logic [OCT_W-1:0]  octave_q, octave_d;
    logic [6:0]        prev_keys_q;
    logic [3:0]        latch_q, latch_d;
    logic [3:0]        note_q, note_d;
    logic              sharp_q, sharp_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic              note_chg_q, note_chg_d;

    logic [6:0]        keys;
    logic [6:0]        rises;
    logic              latched_held;
    logic [3:0]        sel_key;
    logic [3:0]        semi;
    logic [FREQ_W-1:0] pitch;

    function automatic logic [3:0] highest_key(input logic [6:0] k);
        highest_key = 4'd0;
        for (int i = 0; i < 7; i++) begin
            if (k[i]) highest_key = 4'(i + 1);
        end
    endfunction

    function automatic logic [3:0] key_semitone(input logic [3:0] n);
        case (n)
            4'd1:    key_semitone = 4'd0;
            4'd2:    key_semitone = 4'd2;
            4'd3:    key_semitone = 4'd4;
            4'd4:    key_semitone = 4'd5;
            4'd5:    key_semitone = 4'd7;
            4'd6:    key_semitone = 4'd9;
            4'd7:    key_semitone = 4'd11;
            default: key_semitone = 4'd0;
        endcase
    endfunction

    // Semitone 12 (B#) is C one octave up, so its base is simply 2*131.
    function automatic logic [8:0] base_freq(input logic [3:0] s);
        case (s)
            4'd0:    base_freq = 9'd131;
            4'd1:    base_freq = 9'd139;
            4'd2:    base_freq = 9'd147;
            4'd3:    base_freq = 9'd156;
            4'd4:    base_freq = 9'd165;
            4'd5:    base_freq = 9'd175;
            4'd6:    base_freq = 9'd185;
            4'd7:    base_freq = 9'd196;
            4'd8:    base_freq = 9'd208;
            4'd9:    base_freq = 9'd220;
            4'd10:   base_freq = 9'd233;
            4'd11:   base_freq = 9'd247;
            4'd12:   base_freq = 9'd262;
            default: base_freq = 9'd0;
        endcase
    endfunction

    assign keys         = sw[6:0];
    assign rises        = keys & ~prev_keys_q;
    assign latched_held = |(keys & (7'd1 << (latch_q - 4'd1)));

    always_comb begin
        latch_d = latch_q;
        sel_key = 4'd0;
        if (PRIORITY == 0) begin
            if ((keys != 7'd0) && ((keys & (keys - 7'd1)) == 7'd0))
                sel_key = highest_key(keys);
        end else if (PRIORITY == 1) begin
            sel_key = highest_key(keys);
        end else begin
            if (rises != 7'd0)
                latch_d = highest_key(rises);
            else if (latch_q != 4'd0 && latched_held)
                latch_d = latch_q;
            else
                latch_d = highest_key(keys);
            sel_key = latch_d;
        end
    end

    assign semi  = key_semitone(sel_key) + {3'b000, sw[7]};
    assign pitch = FREQ_W'(base_freq(semi)) << octave_q;

    always_comb begin
        octave_d = octave_q;
        if (oct_up && !oct_dn && octave_q != OCT_MAX)
            octave_d = octave_q + OCT_W'(1);
        else if (oct_dn && !oct_up && octave_q != '0)
            octave_d = octave_q - OCT_W'(1);
    end

    // With no key selected, hold keeps the registered note untouched so octave moves never retune it.
    always_comb begin
        note_d  = note_q;
        sharp_d = sharp_q;
        freq_d  = freq_q;
        if (sel_key != 4'd0) begin
            note_d  = sel_key;
            sharp_d = sw[7];
            freq_d  = pitch;
        end else if (!hold) begin
            note_d  = 4'd0;
            sharp_d = 1'b0;
            freq_d  = '0;
        end
        note_chg_d = (note_d != note_q) || (sharp_d != sharp_q) || (freq_d != freq_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            octave_q    <= OCT_RESET;
            prev_keys_q <= 7'd0;
            latch_q     <= 4'd0;
            note_q      <= 4'd0;
            sharp_q     <= 1'b0;
            freq_q      <= '0;
            note_chg_q  <= 1'b0;
        end else if (en) begin
            octave_q    <= octave_d;
            prev_keys_q <= keys;
            latch_q     <= latch_d;
            note_q      <= note_d;
            sharp_q     <= sharp_d;
            freq_q      <= freq_d;
            note_chg_q  <= note_chg_d;
        end else begin
            note_chg_q  <= 1'b0;
        end
    end

    assign frequency = freq_q;
    assign note      = note_q;
    assign sharp     = sharp_q;
    assign octave    = octave_q;
    assign note_chg  = note_chg_q;

endmodule

// File: tb/tb_keyboard_pitch_mapper.sv
// Bench for keyboard_pitch_mapper: one instance per priority mode on shared inputs,
// table-driven vectors and hand sequences scored through an expected-result queue.
module tb_keyboard_pitch_mapper;

    typedef struct {
        logic       en;
        logic       up;
        logic       dn;
        logic       hold;
        logic [7:0] sw;
    } in_t;

    typedef struct {
        int         dut;
        logic [3:0] note;
        logic       sharp;
        logic [11:0] freq;
        logic [1:0] oct;
        logic       chg;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, oct_up, oct_dn, hold;
    logic [7:0] sw;

    logic [11:0] freq_w  [3];
    logic [3:0]  note_w  [3];
    logic        sharp_w [3];
    logic [1:0]  oct_w   [3];
    logic        chg_w   [3];

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];
    vec_t tbl[$];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        keyboard_pitch_mapper #(
            .NUM_OCTAVES(3),
            .MID_OCTAVE (1),
            .FREQ_W     (12),
            .PRIORITY   (gi)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .oct_up   (oct_up),
            .oct_dn   (oct_dn),
            .hold     (hold),
            .sw       (sw),
            .frequency(freq_w[gi]),
            .note     (note_w[gi]),
            .sharp    (sharp_w[gi]),
            .octave   (oct_w[gi]),
            .note_chg (chg_w[gi])
        );
    end

    function automatic exp_t mk_exp(input int d, input int n, input int s, input int f,
                                    input int o, input int c);
        exp_t e;
        e.dut   = d;
        e.note  = 4'(n);
        e.sharp = 1'(s);
        e.freq  = 12'(f);
        e.oct   = 2'(o);
        e.chg   = 1'(c);
        return e;
    endfunction

    task automatic add(input logic en_v, input logic up_v, input logic dn_v, input logic hold_v,
                       input logic [7:0] sw_v, input int n, input int s, input int f,
                       input int o, input int c);
        vec_t v;
        v.i.en   = en_v;
        v.i.up   = up_v;
        v.i.dn   = dn_v;
        v.i.hold = hold_v;
        v.i.sw   = sw_v;
        v.e      = mk_exp(0, n, s, f, o, c);
        tbl.push_back(v);
    endtask

    task automatic set_in(input logic en_v, input logic up_v, input logic dn_v,
                          input logic hold_v, input logic [7:0] sw_v);
        en     = en_v;
        oct_up = up_v;
        oct_dn = dn_v;
        hold   = hold_v;
        sw     = sw_v;
    endtask

    task automatic chk(input string what, input int tag, input int d,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s txn%0d dut%0d: got %0d required %0d", what, tag, d, act, req);
        end
    endtask

    task automatic check_exp(input exp_t e, input int tag);
        chk("note",     tag, e.dut, 32'(note_w[e.dut]),  32'(e.note));
        chk("sharp",    tag, e.dut, 32'(sharp_w[e.dut]), 32'(e.sharp));
        chk("freq",     tag, e.dut, 32'(freq_w[e.dut]),  32'(e.freq));
        chk("octave",   tag, e.dut, 32'(oct_w[e.dut]),   32'(e.oct));
        chk("note_chg", tag, e.dut, 32'(chg_w[e.dut]),   32'(e.chg));
        $display("txn %0d dut%0d sw=%h note=%0d sharp=%0d freq=%0d oct=%0d chg=%0d",
                 tag, e.dut, sw, note_w[e.dut], sharp_w[e.dut], freq_w[e.dut],
                 oct_w[e.dut], chg_w[e.dut]);
    endtask

    // Let one active edge go by, then score every expectation queued for it.
    task automatic cycle_and_score(input int tag);
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard txn%0d: got 0 queued results required at least 1", tag);
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_exp(e, tag);
        end
    endtask

    task automatic check_reset_all(input int tag);
        for (int d = 0; d < 3; d++) check_exp(mk_exp(d, 0, 0, 0, 1, 0), tag);
    endtask

    task automatic pulse_reset(input int tag);
        #2 rst = 1'b0;
        #1 check_reset_all(tag);
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] p2_sw   [6] = '{8'h02, 8'h12, 8'h13, 8'h12, 8'h12, 8'h10};
        int         p2_note [6] = '{2, 5, 1, 5, 5, 5};
        int         p2_freq [6] = '{294, 392, 262, 392, 392, 392};
        int         p2_chg  [6] = '{1, 1, 1, 1, 0, 0};

        //   en up dn hold sw     note sh freq oct chg
        add(1, 0, 0, 0, 8'h01, 1, 0,  262, 1, 1);
        add(1, 0, 0, 0, 8'h01, 1, 0,  262, 1, 0);
        add(1, 0, 0, 0, 8'h20, 6, 0,  440, 1, 1);
        add(1, 1, 0, 0, 8'h20, 6, 0,  440, 2, 0);
        add(1, 1, 0, 0, 8'h20, 6, 0,  880, 2, 1);
        add(1, 1, 0, 0, 8'h20, 6, 0,  880, 2, 0);
        add(1, 0, 1, 0, 8'h20, 6, 0,  880, 1, 0);
        add(1, 0, 1, 0, 8'h20, 6, 0,  440, 0, 1);
        add(1, 0, 1, 0, 8'h20, 6, 0,  220, 0, 1);
        add(1, 0, 1, 0, 8'h20, 6, 0,  220, 0, 0);
        add(1, 0, 1, 0, 8'h20, 6, 0,  220, 0, 0);
        add(1, 1, 1, 0, 8'h20, 6, 0,  220, 0, 0);
        add(1, 0, 0, 0, 8'h20, 6, 0,  220, 0, 0);
        add(1, 1, 0, 0, 8'h20, 6, 0,  220, 1, 0);
        add(1, 1, 0, 0, 8'h20, 6, 0,  440, 2, 1);
        add(1, 1, 1, 0, 8'h20, 6, 0,  880, 2, 1);
        add(1, 0, 0, 0, 8'hC0, 7, 1, 1048, 2, 1);
        add(1, 0, 1, 0, 8'hC0, 7, 1, 1048, 1, 0);
        add(1, 0, 0, 0, 8'h84, 3, 1,  350, 1, 1);
        add(1, 0, 0, 0, 8'h05, 0, 0,    0, 1, 1);
        add(1, 0, 0, 0, 8'h00, 0, 0,    0, 1, 0);
        add(1, 0, 0, 0, 8'h08, 4, 0,  350, 1, 1);
        add(1, 0, 0, 1, 8'h00, 4, 0,  350, 1, 0);
        add(1, 1, 0, 1, 8'h00, 4, 0,  350, 2, 0);
        add(1, 0, 0, 1, 8'h00, 4, 0,  350, 2, 0);
        add(1, 0, 0, 0, 8'h00, 0, 0,    0, 2, 1);
        add(1, 0, 0, 0, 8'h01, 1, 0,  524, 2, 1);
        add(0, 0, 0, 0, 8'h20, 1, 0,  524, 2, 0);
        add(0, 0, 1, 0, 8'h20, 1, 0,  524, 2, 0);
        add(1, 0, 0, 0, 8'h20, 6, 0,  880, 2, 1);
        add(1, 0, 0, 0, 8'h41, 0, 0,    0, 2, 1);

        rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        check_reset_all(0);
        rst = 1'b1;

        foreach (tbl[k]) begin
            set_in(tbl[k].i.en, tbl[k].i.up, tbl[k].i.dn, tbl[k].i.hold, tbl[k].i.sw);
            sb_q.push_back(tbl[k].e);
            cycle_and_score(k + 1);
        end

        // A sounding note, then asynchronous reset in the middle of the cycle.
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
        sb_q.push_back(mk_exp(0, 1, 0, 524, 2, 1));
        cycle_and_score(100);
        pulse_reset(101);

        // Two keys: exact-one mode goes silent, highest-key mode plays E.
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 8'h05);
        sb_q.push_back(mk_exp(1, 3, 0, 330, 1, 1));
        sb_q.push_back(mk_exp(0, 0, 0, 0, 1, 0));
        cycle_and_score(200);
        pulse_reset(201);

        // Last-pressed mode: newest rise wins, release falls back to highest held key.
        for (int k = 0; k < 6; k++) begin
            set_in(1'b1, 1'b0, 1'b0, 1'b0, p2_sw[k]);
            sb_q.push_back(mk_exp(2, p2_note[k], 0, p2_freq[k], 1, p2_chg[k]));
            cycle_and_score(300 + k);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
